riscv_core_mul_iter: RTL and testbench

- Iterative radix-2 shift-add multiplier for the RV64M execute path.
- Sits directly upstream of the multiply result-formatting stage, which consumes a 2*XLEN unsigned magnitude product plus per-operand sign flags and applies two's-complement correction and word/high selection.
- Accepts one operation at a time over a valid/ready handshake.
- Holds the result stable until the downstream stage accepts it.

---
 rtl/riscv_core_mul_iter.sv | 152 +++++++++++++++
 tb/tb_riscv_core_mul_iter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_mul_iter.sv
// rtl/riscv_core_mul_iter.sv - iterative radix-2 shift-add magnitude multiplier for RV64M
module riscv_core_mul_iter #(
    parameter int XLEN = 64
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_mul_valid,
    output logic                o_mul_ready,
    input  logic [XLEN-1:0]     i_mul_srcA,
    input  logic [XLEN-1:0]     i_mul_srcB,
    input  logic [1:0]          i_mul_control,
    input  logic                i_mul_isword,
    input  logic                i_mul_flush,
    output logic                o_mul_valid,
    input  logic                i_mul_out_ready,
    output logic                o_mul_srcA_Dsign,
    output logic                o_mul_srcB_Dsign,
    output logic                o_mul_srcA_Wsign,
    output logic                o_mul_srcB_Wsign,
    output logic [1:0]          o_mul_control,
    output logic                o_mul_isword,
    output logic [2*XLEN-1:0]   o_mul_product
);

    localparam int HW = XLEN / 2;
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [2*XLEN-1:0]   mcand_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     mplier_q;
    logic                ready_q;
    logic                valid_q;
    logic                a_dsign_q, b_dsign_q, a_wsign_q, b_wsign_q;
    logic [1:0]          ctl_q;
    logic                isw_q;
    logic [2*XLEN-1:0]   prod_q;

    logic                a_dsign_d, b_dsign_d, a_wsign_d, b_wsign_d;
    logic [XLEN-1:0]     mag_a_d, mag_b_d;
    logic [XLEN-1:0]     neg_a, neg_b;
    logic [HW-1:0]       neg_lo_a, neg_lo_b;

    assign neg_a    = ~i_mul_srcA + {{(XLEN-1){1'b0}}, 1'b1};
    assign neg_b    = ~i_mul_srcB + {{(XLEN-1){1'b0}}, 1'b1};
    assign neg_lo_a = ~i_mul_srcA[HW-1:0] + {{(HW-1){1'b0}}, 1'b1};
    assign neg_lo_b = ~i_mul_srcB[HW-1:0] + {{(HW-1){1'b0}}, 1'b1};

    // Operand signedness: MULHU treats both unsigned, MULHSU only A signed.
    always_comb begin
        a_dsign_d = 1'b0;
        b_dsign_d = 1'b0;
        a_wsign_d = 1'b0;
        b_wsign_d = 1'b0;
        mag_a_d   = i_mul_srcA;
        mag_b_d   = i_mul_srcB;
        if (i_mul_isword) begin
            a_wsign_d = i_mul_srcA[HW-1];
            b_wsign_d = i_mul_srcB[HW-1];
            mag_a_d   = {{HW{1'b0}}, (a_wsign_d ? neg_lo_a : i_mul_srcA[HW-1:0])};
            mag_b_d   = {{HW{1'b0}}, (b_wsign_d ? neg_lo_b : i_mul_srcB[HW-1:0])};
        end else begin
            a_dsign_d = i_mul_srcA[XLEN-1] & (i_mul_control != 2'b11);
            b_dsign_d = i_mul_srcB[XLEN-1] & ~i_mul_control[1];
            mag_a_d   = a_dsign_d ? neg_a : i_mul_srcA;
            mag_b_d   = b_dsign_d ? neg_b : i_mul_srcB;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            a_dsign_q <= 1'b0;
            b_dsign_q <= 1'b0;
            a_wsign_q <= 1'b0;
            b_wsign_q <= 1'b0;
            ctl_q     <= 2'b00;
            isw_q     <= 1'b0;
            prod_q    <= '0;
        end else if (i_mul_flush) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_mul_valid) begin
                        a_dsign_q <= a_dsign_d;
                        b_dsign_q <= b_dsign_d;
                        a_wsign_q <= a_wsign_d;
                        b_wsign_q <= b_wsign_d;
                        ctl_q     <= i_mul_control;
                        isw_q     <= i_mul_isword;
                        mcand_q   <= {{XLEN{1'b0}}, mag_a_d};
                        mplier_q  <= mag_b_d;
                        acc_q     <= '0;
                        cnt_q     <= i_mul_isword ? CW'(HW) : CW'(XLEN);
                        ready_q   <= 1'b0;
                        state_q   <= CALC;
                    end
                end
                CALC: begin
                    // Counter hits zero after the last step; the following cycle publishes the sum.
                    if (cnt_q != '0) begin
                        if (mplier_q[0]) begin
                            acc_q <= acc_q + mcand_q;
                        end
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q - CW'(1);
                    end else begin
                        prod_q  <= acc_q;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (i_mul_out_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_mul_ready      = ready_q;
    assign o_mul_valid      = valid_q;
    assign o_mul_srcA_Dsign = a_dsign_q;
    assign o_mul_srcB_Dsign = b_dsign_q;
    assign o_mul_srcA_Wsign = a_wsign_q;
    assign o_mul_srcB_Wsign = b_wsign_q;
    assign o_mul_control    = ctl_q;
    assign o_mul_isword     = isw_q;
    assign o_mul_product    = prod_q;

endmodule

// File: tb/tb_riscv_core_mul_iter.sv
// tb/tb_riscv_core_mul_iter.sv - self-checking bench for riscv_core_mul_iter
module tb_riscv_core_mul_iter;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_mul_valid = 1'b0;
    logic          o_mul_ready;
    logic [63:0]   i_mul_srcA = '0;
    logic [63:0]   i_mul_srcB = '0;
    logic [1:0]    i_mul_control = '0;
    logic          i_mul_isword = 1'b0;
    logic          i_mul_flush = 1'b0;
    logic          o_mul_valid;
    logic          i_mul_out_ready = 1'b0;
    logic          o_a_d, o_b_d, o_a_w, o_b_w;
    logic [1:0]    o_mul_control;
    logic          o_mul_isword;
    logic [127:0]  o_mul_product;

    int checks = 0;
    int errors = 0;
    logic [127:0] got_p;

    riscv_core_mul_iter #(.XLEN(64)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_mul_valid(i_mul_valid), .o_mul_ready(o_mul_ready),
        .i_mul_srcA(i_mul_srcA), .i_mul_srcB(i_mul_srcB),
        .i_mul_control(i_mul_control), .i_mul_isword(i_mul_isword),
        .i_mul_flush(i_mul_flush), .o_mul_valid(o_mul_valid),
        .i_mul_out_ready(i_mul_out_ready),
        .o_mul_srcA_Dsign(o_a_d), .o_mul_srcB_Dsign(o_b_d),
        .o_mul_srcA_Wsign(o_a_w), .o_mul_srcB_Wsign(o_b_w),
        .o_mul_control(o_mul_control), .o_mul_isword(o_mul_isword),
        .o_mul_product(o_mul_product)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: signedness from the opcode rules, magnitudes by modular negation, product by plain multiply.
    task automatic model(input logic [63:0] a, input logic [63:0] b, input logic [1:0] ctl,
                         input logic isw, output logic [127:0] p,
                         output logic ad, output logic bd, output logic aw, output logic bw);
        logic [63:0] ma, mb;
        ad = 0; bd = 0; aw = 0; bw = 0;
        if (isw) begin
            aw = a[31];
            bw = b[31];
            ma = aw ? ((64'h1_0000_0000 - {32'b0, a[31:0]}) & 64'hFFFF_FFFF) : {32'b0, a[31:0]};
            mb = bw ? ((64'h1_0000_0000 - {32'b0, b[31:0]}) & 64'hFFFF_FFFF) : {32'b0, b[31:0]};
        end else begin
            ad = a[63] && (ctl != 2'd3);
            bd = b[63] && (ctl <= 2'd1);
            ma = ad ? 64'd0 - a : a;
            mb = bd ? 64'd0 - b : b;
        end
        p = {64'd0, ma} * {64'd0, mb};
    endtask

    task automatic issue_wait(input logic [63:0] a, input logic [63:0] b, input logic [1:0] ctl,
                              input logic isw, input string tag);
        int cyc;
        @(negedge clk);
        chk({tag, ".ready_idle"}, {127'd0, o_mul_ready}, 128'd1);
        i_mul_valid = 1'b1; i_mul_srcA = a; i_mul_srcB = b;
        i_mul_control = ctl; i_mul_isword = isw;
        @(posedge clk); #1;
        i_mul_valid = 1'b0;
        chk({tag, ".ready_busy"}, {127'd0, o_mul_ready}, 128'd0);
        cyc = 0;
        while (!o_mul_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, ".latency"}, 128'(cyc), isw ? 128'd33 : 128'd65);
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] ctl,
                          input logic isw, input int hold, input string tag);
        logic [127:0] ep;
        logic ad, bd, aw, bw;
        model(a, b, ctl, isw, ep, ad, bd, aw, bw);
        issue_wait(a, b, ctl, isw, tag);
        got_p = o_mul_product;
        chk({tag, ".product"}, o_mul_product, ep);
        chk({tag, ".flags"}, {124'd0, o_a_d, o_b_d, o_a_w, o_b_w}, {124'd0, ad, bd, aw, bw});
        chk({tag, ".ctl_isw"}, {125'd0, o_mul_control, o_mul_isword}, {125'd0, ctl, isw});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold"}, {o_mul_product[125:0], o_mul_valid, o_mul_ready},
                {ep[125:0], 1'b1, 1'b0});
        end
        @(negedge clk);
        i_mul_out_ready = 1'b1;
        @(posedge clk); #1;
        i_mul_out_ready = 1'b0;
        chk({tag, ".release"}, {126'd0, o_mul_valid, o_mul_ready}, 128'd1);
    endtask

    initial begin
        int vhigh;
        logic [63:0] ra, rb;

        #12;
        chk("reset.state", {120'd0, o_mul_valid, o_a_d, o_b_d, o_a_w, o_b_w, o_mul_control, o_mul_isword},
            128'd0);
        chk("reset.product", o_mul_product, 128'd0);
        chk("reset.ready", {127'd0, o_mul_ready}, 128'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 2'b00, 1'b0, 0, "t1_mul");
        chk("t1.const", got_p, 128'd6);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'b11, 1'b0, 0, "t2_mulhu");
        chk("t2.const", got_p, {64'h1, 64'hFFFF_FFFF_FFFF_FFFE});
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 2'b10, 1'b0, 0, "t3_mulhsu");
        chk("t3.const", got_p, 128'd3);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 2'b01, 1'b0, 0, "t3_mulh");
        run_op(64'h0000_0000_FFFF_FFFF, 64'd5, 2'b00, 1'b1, 0, "t4_mulw");
        chk("t4.const", got_p, 128'd5);
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b00, 1'b0, 0, "most_neg");
        chk("most_neg.const", got_p, {2'b01, 126'd0});
        run_op(64'h1234_5678_9ABC_DEF0, 64'd7, 2'b01, 1'b0, 10, "t5_hold");

        // Flush mid-calculation
        @(negedge clk);
        i_mul_valid = 1'b1; i_mul_srcA = 64'd9; i_mul_srcB = 64'd9;
        i_mul_control = 2'b00; i_mul_isword = 1'b0;
        @(posedge clk); #1;
        i_mul_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        i_mul_flush = 1'b1;
        @(posedge clk); #1;
        i_mul_flush = 1'b0;
        chk("t6.flush_idle", {126'd0, o_mul_valid, o_mul_ready}, 128'd1);
        @(negedge clk);
        i_mul_valid = 1'b1; i_mul_flush = 1'b1;
        @(posedge clk); #1;
        i_mul_valid = 1'b0; i_mul_flush = 1'b0;
        chk("t6.flush_drops_req", {127'd0, o_mul_ready}, 128'd1);
        vhigh = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (o_mul_valid) vhigh++;
        end
        chk("t6.no_valid", 128'(vhigh), 128'd0);
        run_op(64'd7, 64'd6, 2'b00, 1'b0, 0, "t6_after");
        chk("t6.const", got_p, 128'd42);

        // Asynchronous reset while in DONE
        issue_wait(64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 2'b00, 1'b0, "t6_rst");
        chk("t6_rst.valid_before", {127'd0, o_mul_valid}, 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst.cleared", {120'd0, o_mul_valid, o_a_d, o_b_d, o_a_w, o_b_w, o_mul_control, o_mul_isword},
            128'd0);
        chk("t6_rst.product", o_mul_product, 128'd0);
        chk("t6_rst.ready", {127'd0, o_mul_ready}, 128'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0: ra = {$urandom, $urandom};
                1: ra = 64'h8000_0000_0000_0000;
                2: ra = 64'($urandom_range(0, 1000));
                default: ra = {$urandom, 32'h8000_0000};
            endcase
            case ($urandom_range(0, 3))
                0: rb = {$urandom, $urandom};
                1: rb = 64'hFFFF_FFFF_FFFF_FFFF;
                2: rb = 64'($urandom_range(0, 1000));
                default: rb = {$urandom, 32'h8000_0000};
            endcase
            run_op(ra, rb, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
